// File: rtl/frame_sequencer.sv
// Raster frame controller: vsync preamble, then HEIGHT rows of WIDTH pixel slots
// separated by horizontal blanking, with a stall-gated pixel-valid strobe.
module frame_sequencer #(
  parameter int WIDTH     = 768,
  parameter int HEIGHT    = 512,
  parameter int VS_CYCLES = 100,
  parameter int HB_CYCLES = 160,
  parameter int X_W       = $clog2(WIDTH),
  parameter int Y_W       = $clog2(HEIGHT)
) (
  input  logic           HCLK,
  input  logic           HRESET,
  input  logic           start,
  input  logic           stall,
  output logic           vsync,
  output logic           hsync,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           busy,
  output logic           frame_done,
  output logic [7:0]     frame_cnt,
  output logic [2:0]     dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_HBLANK = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // One counter serves both the preamble and the blanking interval.
  localparam int CNT_MAX = (VS_CYCLES > HB_CYCLES) ? VS_CYCLES : HB_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [X_W-1:0]   X_LAST  = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(VS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HB_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [X_W-1:0]   r_pix_x;
  logic [Y_W-1:0]   r_pix_y;
  logic             r_vsync;
  logic             r_busy;
  logic             r_frame_done;
  logic [7:0]       r_frame_cnt;

  logic [2:0]       w_next_state;
  logic             w_accept;
  logic             w_row_end;
  logic             w_last_row;

  // Pixel handshake: hsync is valid and stall is an inverted ready. A pixel slot
  // transfers only in a cycle where hsync is high; while stall is high the
  // current coordinates are held, never dropped or advanced.
  assign w_accept   = (r_state == S_ACTIVE) && !stall;
  assign w_row_end  = (r_pix_x == X_LAST);
  assign w_last_row = (r_pix_y == Y_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_VSYNC;
      end
      S_VSYNC: begin
        if (r_cnt == VS_LAST) w_next_state = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_accept && w_row_end) begin
          w_next_state = w_last_row ? S_DONE : S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (r_cnt == HB_LAST) w_next_state = S_ACTIVE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_vsync      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_vsync      <= (w_next_state == S_VSYNC);
      r_busy       <= (w_next_state != S_IDLE);
      r_frame_done <= (w_next_state == S_DONE);
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (r_state == S_VSYNC || r_state == S_HBLANK) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Count lands on the same edge that raises frame_done.
      if (w_next_state == S_DONE) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // Coordinates hold through HBLANK and DONE; they clear only when a frame starts.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else if (w_accept) begin
      if (!w_row_end) begin
        r_pix_x <= r_pix_x + X_W'(1);
      end else if (!w_last_row) begin
        r_pix_x <= '0;
        r_pix_y <= r_pix_y + Y_W'(1);
      end
    end
  end

  assign vsync      = r_vsync;
  assign hsync      = w_accept;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer on a 4x3 raster (VS=2, HB=3); pixel coordinates are
// scoreboarded, timing is compared against closed-form cycle expectations.
module tb_frame_sequencer;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int VS     = 2;
  localparam int HB     = 3;
  localparam int X_W    = $clog2(WIDTH);
  localparam int Y_W    = $clog2(HEIGHT);
  localparam int PW     = X_W + Y_W;
  localparam int MAXC   = 128;
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int DONE_NOM = VS + WIDTH * HEIGHT + (HEIGHT - 1) * HB + 1;

  logic           HCLK = 1'b0;
  logic           HRESET = 1'b0;
  logic           start = 1'b0;
  logic           stall = 1'b0;
  logic           vsync;
  logic           hsync;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           busy;
  logic           frame_done;
  logic [7:0]     frame_cnt;
  logic [2:0]     dbg_state;

  int checks = 0;
  int failures = 0;
  int exp_fc = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mon_e;

  int st_lo0, st_hi0, st_lo1, st_hi1, ign0, ign1;
  logic           vs_log[MAXC];
  logic           hs_log[MAXC];
  logic           busy_log[MAXC];
  logic           fd_log[MAXC];
  logic [X_W-1:0] x_log[MAXC];
  logic [Y_W-1:0] y_log[MAXC];
  int done_cyc;
  int hs_cnt;

  frame_sequencer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .VS_CYCLES(VS), .HB_CYCLES(HB)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .stall(stall),
    .vsync(vsync), .hsync(hsync), .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 HCLK = ~HCLK;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge HCLK) begin
    if (hsync === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pixel_unexpected got=(%0d,%0d) required=none", pix_x, pix_y);
      end else begin
        mon_e = exp_q.pop_front();
        if ({pix_y, pix_x} !== mon_e) begin
          failures++;
          $display("FAIL pixel_order got=(%0d,%0d) required=(%0d,%0d)",
                   pix_x, pix_y, mon_e[X_W-1:0], mon_e[PW-1:X_W]);
        end
      end
    end
  end

  // ---------------- expectation functions ----------------
  function automatic logic exp_hs_nom(input int c);
    int a;
    for (int r = 0; r < HEIGHT; r++) begin
      a = VS + 1 + r * (WIDTH + HB);
      if (c >= a && c < a + WIDTH) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic exp_hs_shift(input int c, input int lo, input int len);
    if (c >= lo && c < lo + len) return 1'b0;
    return exp_hs_nom((c < lo) ? c : c - len);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_cfg();
    st_lo0 = -1; st_hi0 = -1; st_lo1 = -1; st_hi1 = -1;
    ign0 = -1; ign1 = -1;
  endtask

  task automatic apply_reset();
    HRESET = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    HRESET = 1'b0;
    exp_q.delete();
    exp_fc = 0;
  endtask

  task automatic push_frame();
    for (int yy = 0; yy < HEIGHT; yy++)
      for (int xx = 0; xx < WIDTH; xx++)
        exp_q.push_back({Y_W'(yy), X_W'(xx)});
  endtask

  // Entered at posedge+1 of an IDLE cycle (cycle 0); leaves at posedge+1 of done+1.
  task automatic drive_frame();
    done_cyc = -1;
    hs_cnt = 0;
    for (int c = 0; c < MAXC; c++) begin
      vs_log[c] = 1'bx; hs_log[c] = 1'bx; busy_log[c] = 1'bx; fd_log[c] = 1'bx;
    end
    for (int c = 0; c < MAXC; c++) begin
      start = (c == 0) || (c == ign0) || (c == ign1);
      stall = (c >= st_lo0 && c < st_hi0) || (c >= st_lo1 && c < st_hi1);
      if (c == 0) push_frame();
      @(negedge HCLK);
      vs_log[c] = vsync; hs_log[c] = hsync; busy_log[c] = busy; fd_log[c] = frame_done;
      x_log[c] = pix_x; y_log[c] = pix_y;
      if (hsync === 1'b1) hs_cnt++;
      if (frame_done === 1'b1 && done_cyc < 0) done_cyc = c;
      tick();
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    HRESET = 1'b1;
    start = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
    start = 1'b0;
    @(negedge HCLK);
    checks++; if (vsync !== 1'b0) begin failures++; $display("FAIL reset_vsync got=%b required=0", vsync); end
    checks++; if (hsync !== 1'b0) begin failures++; $display("FAIL reset_hsync got=%b required=0", hsync); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b required=0", frame_done); end
    checks++; if (pix_x !== '0 || pix_y !== '0) begin failures++; $display("FAIL reset_coords got=(%0d,%0d) required=(0,0)", pix_x, pix_y); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d required=0", frame_cnt); end
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d required=0", dbg_state); end
    tick();
    @(negedge HCLK);
    checks++; if (busy !== 1'b0 || vsync !== 1'b0) begin failures++; $display("FAIL reset_start_lost got=busy%b/vsync%b required=0/0", busy, vsync); end
    tick();
    exp_fc = 0;
  endtask

  task automatic test_single_frame();
    clear_cfg();
    drive_frame();
    exp_fc = (exp_fc + 1) % 256;
    checks++; if (done_cyc !== DONE_NOM) begin failures++; $display("FAIL single_done_cycle got=%0d required=%0d", done_cyc, DONE_NOM); end
    checks++; if (hs_cnt !== NPIX) begin failures++; $display("FAIL single_pixel_count got=%0d required=%0d", hs_cnt, NPIX); end
    for (int c = 1; c <= DONE_NOM; c++) begin
      checks++; if (vs_log[c] !== (c <= VS)) begin failures++; $display("FAIL single_vsync c=%0d got=%b required=%b", c, vs_log[c], c <= VS); end
      checks++; if (hs_log[c] !== exp_hs_nom(c)) begin failures++; $display("FAIL single_hsync c=%0d got=%b required=%b", c, hs_log[c], exp_hs_nom(c)); end
      checks++; if (busy_log[c] !== 1'b1) begin failures++; $display("FAIL single_busy c=%0d got=%b required=1", c, busy_log[c]); end
      checks++; if (fd_log[c] !== (c == DONE_NOM)) begin failures++; $display("FAIL single_frame_done c=%0d got=%b required=%b", c, fd_log[c], c == DONE_NOM); end
    end
    checks++; if (x_log[DONE_NOM] !== X_W'(WIDTH-1) || y_log[DONE_NOM] !== Y_W'(HEIGHT-1)) begin
      failures++; $display("FAIL single_done_coords got=(%0d,%0d) required=(%0d,%0d)", x_log[DONE_NOM], y_log[DONE_NOM], WIDTH-1, HEIGHT-1);
    end
    checks++; if (frame_cnt !== 8'(exp_fc)) begin failures++; $display("FAIL single_frame_cnt got=%0d required=%0d", frame_cnt, exp_fc); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL single_missing_pixels got=%0d required=0", exp_q.size()); end
    @(negedge HCLK);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b required=0", busy); end
    tick();
  endtask

  task automatic test_stall_pixel();
    clear_cfg();
    st_lo0 = 12; st_hi0 = 17;
    drive_frame();
    exp_fc = (exp_fc + 1) % 256;
    checks++; if (done_cyc !== DONE_NOM + 5) begin failures++; $display("FAIL stallpix_done_cycle got=%0d required=%0d", done_cyc, DONE_NOM + 5); end
    checks++; if (hs_cnt !== NPIX) begin failures++; $display("FAIL stallpix_pixel_count got=%0d required=%0d", hs_cnt, NPIX); end
    for (int c = 1; c <= DONE_NOM + 5; c++) begin
      checks++; if (hs_log[c] !== exp_hs_shift(c, 12, 5)) begin failures++; $display("FAIL stallpix_hsync c=%0d got=%b required=%b", c, hs_log[c], exp_hs_shift(c, 12, 5)); end
    end
    for (int c = 12; c < 17; c++) begin
      checks++; if (x_log[c] !== X_W'(2) || y_log[c] !== Y_W'(1)) begin failures++; $display("FAIL stallpix_hold c=%0d got=(%0d,%0d) required=(2,1)", c, x_log[c], y_log[c]); end
    end
    checks++; if (frame_cnt !== 8'(exp_fc)) begin failures++; $display("FAIL stallpix_frame_cnt got=%0d required=%0d", frame_cnt, exp_fc); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL stallpix_missing_pixels got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_stall_blank();
    clear_cfg();
    st_lo0 = 0; st_hi0 = VS + 1;
    st_lo1 = VS + 1 + WIDTH; st_hi1 = VS + 1 + WIDTH + HB;
    drive_frame();
    exp_fc = (exp_fc + 1) % 256;
    checks++; if (done_cyc !== DONE_NOM) begin failures++; $display("FAIL stallblank_done_cycle got=%0d required=%0d", done_cyc, DONE_NOM); end
    for (int c = 1; c <= DONE_NOM; c++) begin
      checks++; if (vs_log[c] !== (c <= VS)) begin failures++; $display("FAIL stallblank_vsync c=%0d got=%b required=%b", c, vs_log[c], c <= VS); end
      checks++; if (hs_log[c] !== exp_hs_nom(c)) begin failures++; $display("FAIL stallblank_hsync c=%0d got=%b required=%b", c, hs_log[c], exp_hs_nom(c)); end
    end
    checks++; if (frame_cnt !== 8'(exp_fc)) begin failures++; $display("FAIL stallblank_frame_cnt got=%0d required=%0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_ignored_start();
    clear_cfg();
    ign0 = 5; ign1 = 15;
    drive_frame();
    exp_fc = (exp_fc + 1) % 256;
    checks++; if (done_cyc !== DONE_NOM) begin failures++; $display("FAIL ignstart_done_cycle got=%0d required=%0d", done_cyc, DONE_NOM); end
    checks++; if (hs_cnt !== NPIX) begin failures++; $display("FAIL ignstart_pixel_count got=%0d required=%0d", hs_cnt, NPIX); end
    for (int c = 1; c <= DONE_NOM; c++) begin
      checks++; if (vs_log[c] !== (c <= VS)) begin failures++; $display("FAIL ignstart_vsync c=%0d got=%b required=%b", c, vs_log[c], c <= VS); end
      checks++; if (hs_log[c] !== exp_hs_nom(c)) begin failures++; $display("FAIL ignstart_hsync c=%0d got=%b required=%b", c, hs_log[c], exp_hs_nom(c)); end
    end
    checks++; if (frame_cnt !== 8'(exp_fc)) begin failures++; $display("FAIL ignstart_frame_cnt got=%0d required=%0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_back_to_back();
    clear_cfg();
    drive_frame();
    exp_fc = (exp_fc + 1) % 256;
    checks++; if (vs_log[1] !== 1'b1 || vs_log[2] !== 1'b1 || vs_log[3] !== 1'b0) begin
      failures++; $display("FAIL b2b_vsync got=%b%b%b required=110", vs_log[1], vs_log[2], vs_log[3]);
    end
    checks++; if (done_cyc !== DONE_NOM) begin failures++; $display("FAIL b2b_done_cycle got=%0d required=%0d", done_cyc, DONE_NOM); end
    checks++; if (frame_cnt !== 8'(exp_fc)) begin failures++; $display("FAIL b2b_frame_cnt got=%0d required=%0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_wrap();
    apply_reset();
    clear_cfg();
    for (int f = 0; f < 256; f++) begin
      drive_frame();
      exp_fc = (exp_fc + 1) % 256;
      checks++; if (done_cyc !== DONE_NOM) begin failures++; $display("FAIL wrap_done_cycle f=%0d got=%0d required=%0d", f, done_cyc, DONE_NOM); end
      checks++; if (frame_cnt !== 8'(exp_fc)) begin failures++; $display("FAIL wrap_frame_cnt f=%0d got=%0d required=%0d", f, frame_cnt, exp_fc); end
    end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL wrap_final got=%0d required=0", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    int seen;
    clear_cfg();
    push_frame();
    start = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c == 12) HRESET = 1'b1;
      tick();
      start = 1'b0;
    end
    HRESET = 1'b0;
    @(negedge HCLK);
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL rstmid_state got=%0d required=0", dbg_state); end
    checks++; if ({vsync, hsync, busy, frame_done} !== 4'b0000) begin failures++; $display("FAIL rstmid_flags got=%b required=0000", {vsync, hsync, busy, frame_done}); end
    checks++; if (pix_x !== '0 || pix_y !== '0) begin failures++; $display("FAIL rstmid_coords got=(%0d,%0d) required=(0,0)", pix_x, pix_y); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL rstmid_frame_cnt got=%0d required=0", frame_cnt); end
    checks++; if (exp_q.size() !== NPIX - 7) begin failures++; $display("FAIL rstmid_pixels_before got=%0d required=%0d", exp_q.size(), NPIX - 7); end
    exp_q.delete();
    exp_fc = 0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      @(negedge HCLK);
      if (busy !== 1'b0 || frame_done !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_stays_idle got=%0d required=0", seen); end
    tick();
    drive_frame();
    exp_fc = (exp_fc + 1) % 256;
    checks++; if (done_cyc !== DONE_NOM) begin failures++; $display("FAIL rstmid_clean_done got=%0d required=%0d", done_cyc, DONE_NOM); end
    checks++; if (hs_cnt !== NPIX) begin failures++; $display("FAIL rstmid_clean_pixels got=%0d required=%0d", hs_cnt, NPIX); end
    checks++; if (frame_cnt !== 8'(exp_fc)) begin failures++; $display("FAIL rstmid_clean_frame_cnt got=%0d required=%0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_perm_stall();
    int len;
    len = 40;
    clear_cfg();
    st_lo0 = VS + 1; st_hi0 = VS + 1 + len;
    drive_frame();
    exp_fc = (exp_fc + 1) % 256;
    for (int c = VS + 1; c < VS + 1 + len; c++) begin
      checks++; if (busy_log[c] !== 1'b1 || hs_log[c] !== 1'b0) begin failures++; $display("FAIL permstall_flags c=%0d got=busy%b/hsync%b required=1/0", c, busy_log[c], hs_log[c]); end
      checks++; if (x_log[c] !== '0 || y_log[c] !== '0) begin failures++; $display("FAIL permstall_coords c=%0d got=(%0d,%0d) required=(0,0)", c, x_log[c], y_log[c]); end
    end
    for (int c = 1; c <= DONE_NOM + len; c++) begin
      checks++; if (hs_log[c] !== exp_hs_shift(c, VS + 1, len)) begin failures++; $display("FAIL permstall_hsync c=%0d got=%b required=%b", c, hs_log[c], exp_hs_shift(c, VS + 1, len)); end
    end
    checks++; if (done_cyc !== DONE_NOM + len) begin failures++; $display("FAIL permstall_done_cycle got=%0d required=%0d", done_cyc, DONE_NOM + len); end
    checks++; if (hs_cnt !== NPIX) begin failures++; $display("FAIL permstall_pixel_count got=%0d required=%0d", hs_cnt, NPIX); end
    checks++; if (frame_cnt !== 8'(exp_fc)) begin failures++; $display("FAIL permstall_frame_cnt got=%0d required=%0d", frame_cnt, exp_fc); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    clear_cfg();
    test_reset();
    test_single_frame();
    test_stall_pixel();
    test_stall_blank();
    test_ignored_start();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_perm_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
